// File: rtl/axi_master_connector_reg.sv
// AXI master connector with a 2-entry register slice on every channel.
// Fabric-side pulp request/response structs are bridged to a flat m_axi_* master port.
// Optional outstanding-transaction limiter: define AXI_MASTER_CONN_TXN_LIMIT_EN.

package axi_master_connector_reg_pkg;
  typedef struct packed {
    logic [7:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic        lock;
    logic [3:0]  cache;
    logic [2:0]  prot;
    logic [3:0]  qos;
    logic [3:0]  region;
    logic [5:0]  atop;
    logic [0:0]  user;
  } aw_chan_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
    logic [0:0]  user;
  } w_chan_t;

  typedef struct packed {
    logic [7:0] id;
    logic [1:0] resp;
    logic [0:0] user;
  } b_chan_t;

  typedef struct packed {
    logic [7:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic        lock;
    logic [3:0]  cache;
    logic [2:0]  prot;
    logic [3:0]  qos;
    logic [3:0]  region;
    logic [0:0]  user;
  } ar_chan_t;

  typedef struct packed {
    logic [7:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [0:0]  user;
  } r_chan_t;

  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } axi_req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } axi_rsp_t;
endpackage

module axi_master_connector_reg #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned STRB_WIDTH   = DATA_WIDTH / 8,
  parameter int unsigned ID_WIDTH     = 8,
  parameter int unsigned AWUSER_WIDTH = 1,
  parameter int unsigned WUSER_WIDTH  = 1,
  parameter int unsigned BUSER_WIDTH  = 1,
  parameter int unsigned ARUSER_WIDTH = 1,
  parameter int unsigned RUSER_WIDTH  = 1,
  parameter int unsigned MAX_TXNS     = 8,
  parameter type axi_req_t = axi_master_connector_reg_pkg::axi_req_t,
  parameter type axi_rsp_t = axi_master_connector_reg_pkg::axi_rsp_t
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  axi_req_t                axi_req_i,
  output axi_rsp_t                axi_resp_o,
  output logic [ID_WIDTH-1:0]     m_axi_awid,
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [7:0]              m_axi_awlen,
  output logic [2:0]              m_axi_awsize,
  output logic [1:0]              m_axi_awburst,
  output logic                    m_axi_awlock,
  output logic [3:0]              m_axi_awcache,
  output logic [2:0]              m_axi_awprot,
  output logic [3:0]              m_axi_awqos,
  output logic [3:0]              m_axi_awregion,
  output logic [AWUSER_WIDTH-1:0] m_axi_awuser,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [STRB_WIDTH-1:0]   m_axi_wstrb,
  output logic                    m_axi_wlast,
  output logic [WUSER_WIDTH-1:0]  m_axi_wuser,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [ID_WIDTH-1:0]     m_axi_bid,
  input  logic [1:0]              m_axi_bresp,
  input  logic [BUSER_WIDTH-1:0]  m_axi_buser,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  output logic [ID_WIDTH-1:0]     m_axi_arid,
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [7:0]              m_axi_arlen,
  output logic [2:0]              m_axi_arsize,
  output logic [1:0]              m_axi_arburst,
  output logic                    m_axi_arlock,
  output logic [3:0]              m_axi_arcache,
  output logic [2:0]              m_axi_arprot,
  output logic [3:0]              m_axi_arqos,
  output logic [3:0]              m_axi_arregion,
  output logic [ARUSER_WIDTH-1:0] m_axi_aruser,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [ID_WIDTH-1:0]     m_axi_rid,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rlast,
  input  logic [RUSER_WIDTH-1:0]  m_axi_ruser,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready
);

  // Channel index: 0 AW, 1 W, 2 B, 3 AR, 4 R. Payloads are packed side by side in one vector.
  localparam int unsigned NumCh = 5;
  localparam int unsigned AwW   = ID_WIDTH + ADDR_WIDTH + 8 + 3 + 2 + 1 + 4 + 3 + 4 + 4 + AWUSER_WIDTH;
  localparam int unsigned WW    = DATA_WIDTH + STRB_WIDTH + 1 + WUSER_WIDTH;
  localparam int unsigned BW    = ID_WIDTH + 2 + BUSER_WIDTH;
  localparam int unsigned ArW   = ID_WIDTH + ADDR_WIDTH + 8 + 3 + 2 + 1 + 4 + 3 + 4 + 4 + ARUSER_WIDTH;
  localparam int unsigned RW    = ID_WIDTH + DATA_WIDTH + 2 + 1 + RUSER_WIDTH;
  localparam int unsigned OffAw = 0;
  localparam int unsigned OffW  = OffAw + AwW;
  localparam int unsigned OffB  = OffW + WW;
  localparam int unsigned OffAr = OffB + BW;
  localparam int unsigned OffR  = OffAr + ArW;
  localparam int unsigned TotW  = OffR + RW;

  logic [NumCh-1:0] up_valid, up_ready, up_gate, up_push, dn_valid, dn_ready;
  logic [TotW-1:0]  up_data, dn_data;

  // atop is deliberately dropped
  logic unused_atop;
  assign unused_atop = ^axi_req_i.aw.atop;

  assign up_valid = {m_axi_rvalid, axi_req_i.ar_valid, m_axi_bvalid, axi_req_i.w_valid,
                     axi_req_i.aw_valid};
  assign dn_ready = {axi_req_i.r_ready, m_axi_arready, axi_req_i.b_ready, m_axi_wready,
                     m_axi_awready};
  assign up_push  = up_valid & up_ready & up_gate;

  assign up_data[OffAw +: AwW] = {axi_req_i.aw.id, axi_req_i.aw.addr, axi_req_i.aw.len,
                                  axi_req_i.aw.size, axi_req_i.aw.burst, axi_req_i.aw.lock,
                                  axi_req_i.aw.cache, axi_req_i.aw.prot, axi_req_i.aw.qos,
                                  axi_req_i.aw.region, axi_req_i.aw.user};
  assign up_data[OffW +: WW]   = {axi_req_i.w.data, axi_req_i.w.strb, axi_req_i.w.last,
                                  axi_req_i.w.user};
  assign up_data[OffB +: BW]   = {m_axi_bid, m_axi_bresp, m_axi_buser};
  assign up_data[OffAr +: ArW] = {axi_req_i.ar.id, axi_req_i.ar.addr, axi_req_i.ar.len,
                                  axi_req_i.ar.size, axi_req_i.ar.burst, axi_req_i.ar.lock,
                                  axi_req_i.ar.cache, axi_req_i.ar.prot, axi_req_i.ar.qos,
                                  axi_req_i.ar.region, axi_req_i.ar.user};
  assign up_data[OffR +: RW]   = {m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_ruser};

  for (genvar g = 0; g < NumCh; g++) begin : g_slice
    localparam int unsigned W   = (g == 0) ? AwW : (g == 1) ? WW : (g == 2) ? BW :
                                  (g == 3) ? ArW : RW;
    localparam int unsigned Off = (g == 0) ? OffAw : (g == 1) ? OffW : (g == 2) ? OffB :
                                  (g == 3) ? OffAr : OffR;
    logic [1:0]   cnt_q, cnt_d;
    logic         rdy_q, pop;
    logic [W-1:0] e0_q, e1_q, din;

    assign din     = up_data[Off +: W];
    assign pop     = (cnt_q != 2'd0) & dn_ready[g];
    assign cnt_d   = cnt_q + {1'b0, up_push[g]} - {1'b0, pop};

    // Occupancy, registered ready and two-entry storage; e0_q is always the head.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        cnt_q <= 2'd0;
        rdy_q <= 1'b0;
        e0_q  <= '0;
        e1_q  <= '0;
      end else begin
        cnt_q <= cnt_d;
        rdy_q <= (cnt_d != 2'd2);
        if (pop) begin
          if (cnt_q == 2'd2)   e0_q <= e1_q;
          else if (up_push[g]) e0_q <= din;
        end else if (up_push[g]) begin
          if (cnt_q == 2'd0) e0_q <= din;
          else               e1_q <= din;
        end
      end
    end

    assign up_ready[g]       = rdy_q;
    assign dn_valid[g]       = (cnt_q != 2'd0);
    assign dn_data[Off +: W] = e0_q;
  end

`ifdef AXI_MASTER_CONN_TXN_LIMIT_EN
  localparam int unsigned CntW = $clog2(MAX_TXNS + 1);
  logic [CntW-1:0] wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
  logic            wr_inc, wr_dec, rd_inc, rd_dec;

  assign up_gate = {1'b1, (rd_cnt_q < CntW'(MAX_TXNS)), 1'b1, 1'b1, (wr_cnt_q < CntW'(MAX_TXNS))};
  assign wr_inc  = up_push[0];
  assign rd_inc  = up_push[3];
  // Guard the decrement so a stray response can never wrap the counter.
  assign wr_dec  = dn_valid[2] & dn_ready[2] & (wr_cnt_q != '0);
  assign rd_dec  = dn_valid[4] & dn_ready[4] & dn_data[OffR + RUSER_WIDTH] & (rd_cnt_q != '0);

  // Next outstanding counts; simultaneous inc/dec holds.
  always_comb begin
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    if (wr_inc && !wr_dec) wr_cnt_d = wr_cnt_q + 1'b1;
    if (!wr_inc && wr_dec) wr_cnt_d = wr_cnt_q - 1'b1;
    if (rd_inc && !rd_dec) rd_cnt_d = rd_cnt_q + 1'b1;
    if (!rd_inc && rd_dec) rd_cnt_d = rd_cnt_q - 1'b1;
  end

  // Outstanding transaction counters.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
    end else begin
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
    end
  end
`else
  logic unused_max_txns;
  assign unused_max_txns = ^MAX_TXNS;
  assign up_gate = '1;
`endif

  assign {m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awlock,
          m_axi_awcache, m_axi_awprot, m_axi_awqos, m_axi_awregion, m_axi_awuser} =
         dn_data[OffAw +: AwW];
  assign {m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wuser} = dn_data[OffW +: WW];
  assign {m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arlock,
          m_axi_arcache, m_axi_arprot, m_axi_arqos, m_axi_arregion, m_axi_aruser} =
         dn_data[OffAr +: ArW];
  assign m_axi_awvalid = dn_valid[0];
  assign m_axi_wvalid  = dn_valid[1];
  assign m_axi_arvalid = dn_valid[3];
  assign m_axi_bready  = up_ready[2];
  assign m_axi_rready  = up_ready[4];

  // Fabric-side response struct assembly.
  always_comb begin
    axi_resp_o          = '0;
    axi_resp_o.aw_ready = up_ready[0] & up_gate[0];
    axi_resp_o.w_ready  = up_ready[1];
    axi_resp_o.ar_ready = up_ready[3] & up_gate[3];
    axi_resp_o.b_valid  = dn_valid[2];
    axi_resp_o.r_valid  = dn_valid[4];
    {axi_resp_o.b.id, axi_resp_o.b.resp, axi_resp_o.b.user} = dn_data[OffB +: BW];
    {axi_resp_o.r.id, axi_resp_o.r.data, axi_resp_o.r.resp, axi_resp_o.r.last,
     axi_resp_o.r.user} = dn_data[OffR +: RW];
  end

endmodule

// File: tb/tb_axi_master_connector_reg.sv
// Self-checking bench for axi_master_connector_reg: directed steps plus a randomized
// valid/ready run against per-channel FIFO queues (every channel is an in-order buffer).
module tb_axi_master_connector_reg;
  import axi_master_connector_reg_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi_req_t req;
  axi_rsp_t rsp;

  logic [7:0]  m_axi_awid, m_axi_awlen, m_axi_arid, m_axi_arlen;
  logic [31:0] m_axi_awaddr, m_axi_araddr, m_axi_wdata;
  logic [2:0]  m_axi_awsize, m_axi_awprot, m_axi_arsize, m_axi_arprot;
  logic [1:0]  m_axi_awburst, m_axi_arburst;
  logic        m_axi_awlock, m_axi_arlock, m_axi_awvalid, m_axi_arvalid, m_axi_wvalid;
  logic [3:0]  m_axi_awcache, m_axi_awqos, m_axi_awregion, m_axi_wstrb;
  logic [3:0]  m_axi_arcache, m_axi_arqos, m_axi_arregion;
  logic [0:0]  m_axi_awuser, m_axi_aruser, m_axi_wuser, m_axi_buser, m_axi_ruser;
  logic        m_axi_wlast, m_axi_bready, m_axi_rready;
  logic        m_axi_awready = 1'b0, m_axi_wready = 1'b0, m_axi_arready = 1'b0;
  logic [7:0]  m_axi_bid, m_axi_rid;
  logic [1:0]  m_axi_bresp, m_axi_rresp;
  logic        m_axi_bvalid, m_axi_rvalid, m_axi_rlast;
  logic [31:0] m_axi_rdata;

  axi_master_connector_reg dut (
    .clk_i(clk), .rst_i(rst), .axi_req_i(req), .axi_resp_o(rsp),
    .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
    .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot), .m_axi_awqos(m_axi_awqos),
    .m_axi_awregion(m_axi_awregion), .m_axi_awuser(m_axi_awuser),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wuser(m_axi_wuser), .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_buser(m_axi_buser),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
    .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot), .m_axi_arqos(m_axi_arqos),
    .m_axi_arregion(m_axi_arregion), .m_axi_aruser(m_axi_aruser),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast), .m_axi_ruser(m_axi_ruser), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready)
  );

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  logic [127:0] sbq [5][$];
  logic [4:0]   uv, ur, dv, dr, pend, hold;
  logic [127:0] prev_pk [5];
  logic [127:0] exp_pk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    assert (obs === expv) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Channel 0 AW, 1 W, 2 B, 3 AR, 4 R; "up" is the producer side, "dn" the consumer side.
  function automatic logic [127:0] up_pk(input int ch);
    case (ch)
      0: return 128'({req.aw.id, req.aw.addr, req.aw.len, req.aw.size, req.aw.burst,
                      req.aw.lock, req.aw.cache, req.aw.prot, req.aw.qos, req.aw.region,
                      req.aw.user});
      1: return 128'({req.w.data, req.w.strb, req.w.last, req.w.user});
      2: return 128'({m_axi_bid, m_axi_bresp, m_axi_buser});
      3: return 128'({req.ar.id, req.ar.addr, req.ar.len, req.ar.size, req.ar.burst,
                      req.ar.lock, req.ar.cache, req.ar.prot, req.ar.qos, req.ar.region,
                      req.ar.user});
      default: return 128'({m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_ruser});
    endcase
  endfunction

  function automatic logic [127:0] dn_pk(input int ch);
    case (ch)
      0: return 128'({m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst,
                      m_axi_awlock, m_axi_awcache, m_axi_awprot, m_axi_awqos, m_axi_awregion,
                      m_axi_awuser});
      1: return 128'({m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wuser});
      2: return 128'({rsp.b.id, rsp.b.resp, rsp.b.user});
      3: return 128'({m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
                      m_axi_arlock, m_axi_arcache, m_axi_arprot, m_axi_arqos, m_axi_arregion,
                      m_axi_aruser});
      default: return 128'({rsp.r.id, rsp.r.data, rsp.r.resp, rsp.r.last, rsp.r.user});
    endcase
  endfunction

  task automatic set_up(input int ch, input logic v);
    logic [127:0] rnd;
    rnd = {$urandom(), $urandom(), $urandom(), $urandom()};
    case (ch)
      0: begin req.aw_valid = v; if (v) req.aw = rnd[$bits(aw_chan_t)-1:0]; end
      1: begin req.w_valid = v; if (v) req.w = rnd[$bits(w_chan_t)-1:0]; end
      2: begin m_axi_bvalid = v; if (v) {m_axi_bid, m_axi_bresp, m_axi_buser} = rnd[10:0]; end
      3: begin req.ar_valid = v; if (v) req.ar = rnd[$bits(ar_chan_t)-1:0]; end
      default: begin
        m_axi_rvalid = v;
        if (v) {m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_ruser} = rnd[43:0];
      end
    endcase
  endtask

  task automatic set_dn_ready(input int ch, input logic v);
    case (ch)
      0: m_axi_awready = v;
      1: m_axi_wready = v;
      2: req.b_ready = v;
      3: m_axi_arready = v;
      default: req.r_ready = v;
    endcase
  endtask

  // One random (or draining) cycle with scoreboard update and stability checks.
  task automatic rand_cycle(input bit drain);
    for (int ch = 0; ch < 5; ch++) begin
      if (!pend[ch]) set_up(ch, drain ? 1'b0 : 1'($urandom_range(0, 1)));
      set_dn_ready(ch, drain ? 1'b1 : ($urandom_range(0, 3) != 0));
    end
    @(negedge clk);
    uv = {m_axi_rvalid, req.ar_valid, m_axi_bvalid, req.w_valid, req.aw_valid};
    ur = {m_axi_rready, rsp.ar_ready, m_axi_bready, rsp.w_ready, rsp.aw_ready};
    dv = {rsp.r_valid, m_axi_arvalid, rsp.b_valid, m_axi_wvalid, m_axi_awvalid};
    dr = {req.r_ready, m_axi_arready, req.b_ready, m_axi_wready, m_axi_awready};
    for (int ch = 0; ch < 5; ch++) begin
      if (hold[ch]) check($sformatf("stable_ch%0d", ch), {dv[ch], dn_pk(ch)[126:0]},
                          {1'b1, prev_pk[ch][126:0]});
      if (dv[ch] && dr[ch]) begin
        if (sbq[ch].size() == 0) begin
          check($sformatf("extra_beat_ch%0d", ch), 128'd1, 128'd0);
        end else begin
          exp_pk = sbq[ch].pop_front();
          check($sformatf("beat_ch%0d", ch), dn_pk(ch), exp_pk);
        end
      end
      hold[ch]    = dv[ch] && !dr[ch];
      prev_pk[ch] = dn_pk(ch);
      if (uv[ch] && ur[ch]) sbq[ch].push_back(up_pk(ch));
      pend[ch] = uv[ch] && !ur[ch];
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    req = '0;
    {m_axi_bid, m_axi_bresp, m_axi_buser, m_axi_bvalid} = '0;
    {m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_ruser, m_axi_rvalid} = '0;
    pend = '0;
    hold = '0;

    // Reset state
    tick(); tick();
    @(negedge clk);
    check("rst_readies", 128'({rsp.aw_ready, rsp.w_ready, rsp.ar_ready, m_axi_bready,
                               m_axi_rready}), 128'd0);
    check("rst_valids", 128'({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, rsp.b_valid,
                              rsp.r_valid}), 128'd0);
    check("rst_payload", 128'({m_axi_awaddr, m_axi_wdata, rsp.r.data}), 128'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_fall_cycle_ready", 128'({rsp.aw_ready, m_axi_bready}), 128'd0);
    tick();
    @(negedge clk);
    check("post_rst_readies", 128'({rsp.aw_ready, rsp.w_ready, rsp.ar_ready, m_axi_bready,
                                    m_axi_rready}), 128'h1f);

    // Single write
    tick();
    m_axi_awready = 1'b1; m_axi_wready = 1'b1; m_axi_arready = 1'b1;
    req.b_ready = 1'b1; req.r_ready = 1'b1;
    req.aw_valid = 1'b1; req.aw = '0; req.aw.addr = 32'h1000; req.aw.id = 8'h5;
    req.w_valid = 1'b1; req.w.data = 32'hDEADBEEF; req.w.strb = 4'hf; req.w.last = 1'b1;
    @(negedge clk);
    check("wr_accept", 128'({rsp.aw_ready, rsp.w_ready}), 128'h3);
    tick();
    req.aw_valid = 1'b0; req.w_valid = 1'b0;
    @(negedge clk);
    check("wr_aw_out", 128'({m_axi_awvalid, m_axi_awaddr, m_axi_awlen}),
          128'({1'b1, 32'h1000, 8'h0}));
    check("wr_w_out", 128'({m_axi_wvalid, m_axi_wdata, m_axi_wlast}),
          128'({1'b1, 32'hDEADBEEF, 1'b1}));
    tick();
    m_axi_bvalid = 1'b1; m_axi_bid = 8'h5; m_axi_bresp = 2'b00; m_axi_buser = 1'b0;
    @(negedge clk);
    check("wr_bready", 128'(m_axi_bready), 128'd1);
    tick();
    m_axi_bvalid = 1'b0;
    @(negedge clk);
    check("wr_b_fabric", 128'({rsp.b_valid, rsp.b.id, rsp.b.resp}), 128'({1'b1, 8'h5, 2'b00}));
    tick();
    @(negedge clk);
    check("wr_idle", 128'({m_axi_awvalid, m_axi_wvalid, rsp.b_valid}), 128'd0);

    // 16-beat read burst
    tick();
    req.ar_valid = 1'b1; req.ar = '0; req.ar.addr = 32'h2000; req.ar.len = 8'd15;
    req.ar.id = 8'h3;
    @(negedge clk);
    check("rd_ar_accept", 128'(rsp.ar_ready), 128'd1);
    tick();
    req.ar_valid = 1'b0;
    @(negedge clk);
    check("rd_ar_out", 128'({m_axi_arvalid, m_axi_araddr, m_axi_arlen}),
          128'({1'b1, 32'h2000, 8'd15}));
    for (int i = 0; i <= 16; i++) begin
      tick();
      m_axi_rvalid = (i < 16);
      m_axi_rid = 8'h3; m_axi_rresp = 2'b00; m_axi_ruser = 1'b0;
      m_axi_rdata = 32'hA000_0000 + i;
      m_axi_rlast = (i == 15);
      @(negedge clk);
      if (i < 16) check($sformatf("rd_rready_%0d", i), 128'(m_axi_rready), 128'd1);
      if (i >= 1) check($sformatf("rd_beat_%0d", i - 1),
                        128'({rsp.r_valid, rsp.r.data, rsp.r.last}),
                        128'({1'b1, 32'hA000_0000 + 32'(i - 1), (i == 16)}));
    end
    tick();
    @(negedge clk);
    check("rd_idle", 128'(rsp.r_valid), 128'd0);

    // AW back-pressure
    tick();
    m_axi_awready = 1'b0;
    req.aw = '0; req.aw_valid = 1'b1; req.aw.addr = 32'hA0;
    @(negedge clk);
    check("bp_aw0_acc", 128'(rsp.aw_ready), 128'd1);
    tick();
    req.aw.addr = 32'hA1;
    @(negedge clk);
    check("bp_aw1_acc", 128'(rsp.aw_ready), 128'd1);
    check("bp_head_c1", 128'({m_axi_awvalid, m_axi_awaddr}), 128'({1'b1, 32'hA0}));
    tick();
    req.aw.addr = 32'hA2;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check($sformatf("bp_stall_%0d", i), 128'({rsp.aw_ready, m_axi_awvalid, m_axi_awaddr}),
            128'({1'b0, 1'b1, 32'hA0}));
      tick();
    end
    m_axi_awready = 1'b1;
    @(negedge clk);
    check("bp_pop0", 128'({rsp.aw_ready, m_axi_awvalid, m_axi_awaddr}),
          128'({1'b0, 1'b1, 32'hA0}));
    tick();
    @(negedge clk);
    check("bp_pop1", 128'({rsp.aw_ready, m_axi_awvalid, m_axi_awaddr}),
          128'({1'b1, 1'b1, 32'hA1}));
    tick();
    req.aw_valid = 1'b0;
    @(negedge clk);
    check("bp_pop2", 128'({m_axi_awvalid, m_axi_awaddr}), 128'({1'b1, 32'hA2}));
    tick();
    @(negedge clk);
    check("bp_empty", 128'(m_axi_awvalid), 128'd0);

    // Reset with two W beats buffered
    tick();
    m_axi_wready = 1'b0;
    req.w_valid = 1'b1; req.w = '0; req.w.data = 32'h1111_1111;
    @(negedge clk);
    tick();
    req.w.data = 32'h2222_2222;
    @(negedge clk);
    tick();
    req.w_valid = 1'b0;
    @(negedge clk);
    check("mrst_full", 128'({rsp.w_ready, m_axi_wvalid, m_axi_wdata}),
          128'({1'b0, 1'b1, 32'h1111_1111}));
    tick();
    rst = 1'b1;
    tick();
    @(negedge clk);
    check("mrst_valids", 128'({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, rsp.b_valid,
                               rsp.r_valid, m_axi_wdata}), 128'd0);
    check("mrst_readies", 128'({rsp.aw_ready, rsp.w_ready, rsp.ar_ready, m_axi_bready,
                                m_axi_rready}), 128'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("mrst_fall_cycle", 128'({rsp.aw_ready, rsp.w_ready, m_axi_rready}), 128'd0);
    tick();
    @(negedge clk);
    check("mrst_ready_back", 128'({rsp.aw_ready, rsp.w_ready, rsp.ar_ready, m_axi_bready,
                                   m_axi_rready, m_axi_wvalid}), 128'h3e);
    tick();

    // Random traffic on all channels, then drain and confirm nothing is left behind
    for (int c = 0; c < 10000; c++) rand_cycle(1'b0);
    for (int c = 0; c < 12; c++) rand_cycle(1'b1);
    for (int ch = 0; ch < 5; ch++) begin
      check($sformatf("lost_beats_ch%0d", ch), 128'(sbq[ch].size()), 128'd0);
    end
    check("drain_valids", 128'({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, rsp.b_valid,
                                rsp.r_valid}), 128'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
